// File: rtl/register_dump_reader.sv
// Debug reader that walks the register file two registers at a time and
// streams every word out over a valid/ready handshake, tagged with its index.
module register_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutIndex,
  output logic [DATA_W-1:0] OutData
);

  typedef enum logic [2:0] {IDLE, FETCH, SEND_LO, SEND_HI, DONE} stateT;

  stateT             state, nextState;
  logic [ADDR_W-2:0] pair, pairNext;
  logic [DATA_W-1:0] bufLo, bufHi;
  logic              lastPair;

  assign lastPair = &pair;

  // Buffers are loaded only on the FETCH edge, so later register-file writes
  // cannot change a pair that is already waiting to be sent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      pair  <= '0;
      bufLo <= '0;
      bufHi <= '0;
    end else begin
      state <= nextState;
      pair  <= pairNext;
      if (state == FETCH) begin
        bufLo <= ReadData1;
        bufHi <= ReadData2;
      end
    end
  end

  always_comb begin
    nextState = state;
    pairNext  = pair;
    case (state)
      IDLE: begin
        if (Start) begin
          pairNext  = '0;
          nextState = FETCH;
        end
      end
      FETCH:   nextState = SEND_LO;
      SEND_LO: begin
        if (OutReady) nextState = SEND_HI;
      end
      SEND_HI: begin
        if (OutReady) begin
          if (lastPair) begin
            nextState = DONE;
          end else begin
            pairNext  = pair + 1'b1;
            nextState = FETCH;
          end
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign ReadReg1 = {pair, 1'b0};
  assign ReadReg2 = {pair, 1'b1};
  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);

  // Output word depends only on registered state, never on OutReady.
  always_comb begin
    OutValid = 1'b0;
    OutIndex = '0;
    OutData  = '0;
    case (state)
      SEND_LO: begin
        OutValid = 1'b1;
        OutIndex = {pair, 1'b0};
        OutData  = bufLo;
      end
      SEND_HI: begin
        OutValid = 1'b1;
        OutIndex = {pair, 1'b1};
        OutData  = bufHi;
      end
      default: begin
        OutValid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_register_dump_reader.sv
// Self-checking bench for register_dump_reader: a register-file array feeds the
// read ports and a cycle-level model predicts acceptance cycles and Done timing.
module tb_register_dump_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;
  localparam int MAXCYC = 600;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              Start = 1'b0;
  logic              Busy, Done, OutValid;
  logic              OutReady = 1'b0;
  logic [ADDR_W-1:0] ReadReg1, ReadReg2, OutIndex;
  logic [DATA_W-1:0] ReadData1, ReadData2, OutData;

  logic [DATA_W-1:0] regFile [NREGS];
  logic [DATA_W-1:0] snap [NREGS];
  logic              readyPat [MAXCYC+1];

  int gotIdx[$];
  int gotCyc[$];
  int doneCyc[$];
  logic [DATA_W-1:0] gotData[$];
  int expCyc [NREGS];
  int expDone, busyFirst, busyLast, busyCount, unstable, endCyc;
  int errors = 0;
  int checks = 0;

  assign ReadData1 = regFile[ReadReg1];
  assign ReadData2 = regFile[ReadReg2];

  always #5 CLK = ~CLK;

  register_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Busy(Busy), .Done(Done),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutIndex(OutIndex), .OutData(OutData)
  );

  // Reference timing: word w is accepted in the first ready cycle once it is
  // presented; a pair costs one fetch cycle; Done follows the last acceptance.
  task automatic computeExpected();
    int c;
    c = 2;
    for (int w = 0; w < NREGS; w++) begin
      while (c < MAXCYC && !readyPat[c]) c++;
      expCyc[w] = c;
      c++;
      if ((w % 2 == 1) && (w != NREGS - 1)) c++;
    end
    expDone = c;
  endtask

  // Drives one dump: Start sampled at edge 0, then cycle c is observed at the
  // falling edge inside it. Stops when Busy falls, at stopAt, or at MAXCYC.
  task automatic runDump(input int writeCyc, input int pulseA, input int pulseB,
                         input bit holdStart, input int stopAt);
    bit prevStall;
    logic [ADDR_W-1:0] prevIdx;
    logic [DATA_W-1:0] prevData;
    gotIdx.delete(); gotCyc.delete(); gotData.delete(); doneCyc.delete();
    busyFirst = -1; busyLast = -1; busyCount = 0; unstable = 0;
    prevStall = 1'b0; prevIdx = '0; prevData = '0;
    endCyc = MAXCYC;
    @(negedge CLK);
    Start = 1'b1;
    OutReady = 1'b0;
    @(negedge CLK);
    if (!holdStart) Start = 1'b0;
    for (int c = 1; c < MAXCYC; c++) begin
      if (c == stopAt) begin
        endCyc = c;
        return;
      end
      if (Busy) begin
        if (busyFirst < 0) busyFirst = c;
        busyLast = c;
        busyCount++;
      end
      if (Done) doneCyc.push_back(c);
      if (prevStall && (OutValid !== 1'b1 || OutIndex !== prevIdx || OutData !== prevData))
        unstable++;
      if (!holdStart) Start = (c == pulseA) || (c == pulseB);
      OutReady = readyPat[c];
      if (c == writeCyc) regFile[7] = 32'hDEADBEEF;
      if (OutValid && OutReady) begin
        gotIdx.push_back(int'(OutIndex));
        gotData.push_back(OutData);
        gotCyc.push_back(c);
      end
      prevStall = OutValid && !OutReady;
      prevIdx   = OutIndex;
      prevData  = OutData;
      if (!Busy && c > 1) begin
        endCyc = c;
        break;
      end
      @(negedge CLK);
    end
    OutReady = 1'b0;
    if (!holdStart) Start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", Busy); end
    checks++; if (Done !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done got=%b want=0", Done); end
    checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", OutValid); end
    checks++; if (OutIndex !== 5'd0) begin errors++; $display("[TB] FAIL reset_index got=%0d want=0", OutIndex); end
    checks++; if (OutData !== 32'd0) begin errors++; $display("[TB] FAIL reset_data got=%h want=0", OutData); end
    checks++; if (ReadReg1 !== 5'd0) begin errors++; $display("[TB] FAIL reset_rr1 got=%0d want=0", ReadReg1); end
    checks++; if (ReadReg2 !== 5'd1) begin errors++; $display("[TB] FAIL reset_rr2 got=%0d want=1", ReadReg2); end
    #1 RST = 1'b0;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < NREGS; i++) regFile[i] = 32'hA5A50000 + i;
    regFile[0] = '0;
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    snap = regFile;
    computeExpected();
    runDump(-1, -1, -1, 1'b0, -1);
    checks++; if (gotIdx.size() != NREGS) begin errors++; $display("[TB] FAIL full_count got=%0d want=%0d", gotIdx.size(), NREGS); end
    for (int w = 0; w < gotIdx.size() && w < NREGS; w++) begin
      checks++; if (gotIdx[w] != w) begin errors++; $display("[TB] FAIL full_idx%0d got=%0d want=%0d", w, gotIdx[w], w); end
      checks++; if (gotData[w] !== snap[w]) begin errors++; $display("[TB] FAIL full_data%0d got=%h want=%h", w, gotData[w], snap[w]); end
      checks++; if (gotCyc[w] != expCyc[w]) begin errors++; $display("[TB] FAIL full_cyc%0d got=%0d want=%0d", w, gotCyc[w], expCyc[w]); end
    end
    if (gotData.size() > 0) begin
      checks++; if (gotData[0] !== 32'd0) begin errors++; $display("[TB] FAIL full_reg0 got=%h want=0", gotData[0]); end
    end
    checks++; if (doneCyc.size() != 1) begin errors++; $display("[TB] FAIL full_donecount got=%0d want=1", doneCyc.size()); end
    if (doneCyc.size() > 0) begin
      checks++; if (doneCyc[0] != 49) begin errors++; $display("[TB] FAIL full_donecyc got=%0d want=49", doneCyc[0]); end
    end
    checks++; if (busyFirst != 1)  begin errors++; $display("[TB] FAIL full_busyfirst got=%0d want=1", busyFirst); end
    checks++; if (busyLast != 49)  begin errors++; $display("[TB] FAIL full_busylast got=%0d want=49", busyLast); end
    checks++; if (busyCount != 49) begin errors++; $display("[TB] FAIL full_busycount got=%0d want=49", busyCount); end
    checks++; if (endCyc != 50)    begin errors++; $display("[TB] FAIL full_idlecyc got=%0d want=50", endCyc); end
  endtask

  task automatic test_backpressure(input bit randomReady);
    int stalls;
    for (int i = 0; i < NREGS; i++) regFile[i] = $urandom();
    for (int i = 0; i <= MAXCYC; i++)
      readyPat[i] = randomReady ? ($urandom_range(0, 2) != 0) : ((i % 4 == 0) || (i % 4 == 3));
    snap = regFile;
    computeExpected();
    stalls = expDone - 49;
    runDump(-1, -1, -1, 1'b0, -1);
    checks++; if (gotIdx.size() != NREGS) begin errors++; $display("[TB] FAIL bp_count got=%0d want=%0d", gotIdx.size(), NREGS); end
    for (int w = 0; w < gotIdx.size() && w < NREGS; w++) begin
      checks++; if (gotIdx[w] != w) begin errors++; $display("[TB] FAIL bp_idx%0d got=%0d want=%0d", w, gotIdx[w], w); end
      checks++; if (gotData[w] !== snap[w]) begin errors++; $display("[TB] FAIL bp_data%0d got=%h want=%h", w, gotData[w], snap[w]); end
      checks++; if (gotCyc[w] != expCyc[w]) begin errors++; $display("[TB] FAIL bp_cyc%0d got=%0d want=%0d", w, gotCyc[w], expCyc[w]); end
    end
    checks++; if (doneCyc.size() != 1) begin errors++; $display("[TB] FAIL bp_donecount got=%0d want=1", doneCyc.size()); end
    if (doneCyc.size() > 0) begin
      checks++; if (doneCyc[0] != 49 + stalls) begin errors++; $display("[TB] FAIL bp_donecyc got=%0d want=%0d", doneCyc[0], 49 + stalls); end
    end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL bp_stable got=%0d want=0", unstable); end
  endtask

  task automatic test_write_during_stall();
    for (int i = 0; i < NREGS; i++) regFile[i] = $urandom();
    regFile[7] = 32'h12345678;
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    readyPat[11] = 1'b0;
    snap = regFile;
    computeExpected();
    runDump(11, -1, -1, 1'b0, -1);
    checks++; if (gotIdx.size() != NREGS) begin errors++; $display("[TB] FAIL wr_count got=%0d want=%0d", gotIdx.size(), NREGS); end
    for (int w = 0; w < gotIdx.size() && w < NREGS; w++) begin
      checks++; if (gotData[w] !== snap[w]) begin errors++; $display("[TB] FAIL wr_data%0d got=%h want=%h", w, gotData[w], snap[w]); end
    end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL wr_stable got=%0d want=0", unstable); end
    if (doneCyc.size() > 0) begin
      checks++; if (doneCyc[0] != expDone) begin errors++; $display("[TB] FAIL wr_donecyc got=%0d want=%0d", doneCyc[0], expDone); end
    end
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    runDump(-1, -1, -1, 1'b0, -1);
    checks++; if (gotData.size() < 8) begin errors++; $display("[TB] FAIL wr2_count got=%0d want=32", gotData.size()); end
    else begin
      checks++; if (gotData[7] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr2_word7 got=%h want=deadbeef", gotData[7]); end
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < NREGS; i++) regFile[i] = $urandom();
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    snap = regFile;
    runDump(-1, 10, 30, 1'b0, -1);
    checks++; if (gotIdx.size() != NREGS) begin errors++; $display("[TB] FAIL sb_count got=%0d want=%0d", gotIdx.size(), NREGS); end
    for (int w = 0; w < gotIdx.size() && w < NREGS; w++) begin
      checks++; if (gotIdx[w] != w || gotData[w] !== snap[w]) begin errors++; $display("[TB] FAIL sb_word%0d got=%0d/%h want=%0d/%h", w, gotIdx[w], gotData[w], w, snap[w]); end
    end
    checks++; if (doneCyc.size() != 1) begin errors++; $display("[TB] FAIL sb_donecount got=%0d want=1", doneCyc.size()); end
    @(negedge CLK);
    checks++; if (Busy !== 1'b0) begin errors++; $display("[TB] FAIL sb_noqueue got=%b want=0", Busy); end
  endtask

  task automatic test_reset_mid_dump();
    int lateDone;
    for (int i = 0; i < NREGS; i++) regFile[i] = $urandom();
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    snap = regFile;
    runDump(-1, -1, -1, 1'b0, 20);
    checks++; if (OutValid !== 1'b1 || OutIndex !== 5'd12) begin errors++; $display("[TB] FAIL rm_prestate got=%b/%0d want=1/12", OutValid, OutIndex); end
    checks++; if (gotIdx.size() != 12) begin errors++; $display("[TB] FAIL rm_prewords got=%0d want=12", gotIdx.size()); end
    #2 RST = 1'b1;
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("[TB] FAIL rm_valid got=%b want=0", OutValid); end
    checks++; if (Busy !== 1'b0)     begin errors++; $display("[TB] FAIL rm_busy got=%b want=0", Busy); end
    checks++; if (ReadReg1 !== 5'd0 || ReadReg2 !== 5'd1) begin errors++; $display("[TB] FAIL rm_rr got=%0d/%0d want=0/1", ReadReg1, ReadReg2); end
    #1 RST = 1'b0;
    OutReady = 1'b0;
    lateDone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (Done || Busy) lateDone++;
    end
    checks++; if (lateDone != 0) begin errors++; $display("[TB] FAIL rm_quiet got=%0d want=0", lateDone); end
    runDump(-1, -1, -1, 1'b0, -1);
    checks++; if (gotIdx.size() != NREGS) begin errors++; $display("[TB] FAIL rm_count got=%0d want=%0d", gotIdx.size(), NREGS); end
    for (int w = 0; w < gotIdx.size() && w < NREGS; w++) begin
      checks++; if (gotIdx[w] != w || gotData[w] !== snap[w]) begin errors++; $display("[TB] FAIL rm_word%0d got=%0d/%h want=%0d/%h", w, gotIdx[w], gotData[w], w, snap[w]); end
    end
    checks++; if (doneCyc.size() != 1 || doneCyc[0] != 49) begin errors++; $display("[TB] FAIL rm_done got=%0d pulses want=1 at 49", doneCyc.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    runDump(-1, -1, -1, 1'b1, -1);
    checks++; if (endCyc != 50) begin errors++; $display("[TB] FAIL b2b_idlecyc got=%0d want=50", endCyc); end
    checks++; if (doneCyc.size() != 1) begin errors++; $display("[TB] FAIL b2b_donecount got=%0d want=1", doneCyc.size()); end
    @(negedge CLK);
    checks++; if (Busy !== 1'b1 || ReadReg1 !== 5'd0) begin errors++; $display("[TB] FAIL b2b_restart got=%b/%0d want=1/0", Busy, ReadReg1); end
    Start = 1'b0;
    #2 RST = 1'b1;
    #2 RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) regFile[i] = '0;
    for (int i = 0; i <= MAXCYC; i++) readyPat[i] = 1'b1;
    test_reset();
    test_full_dump();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_write_during_stall();
    test_start_while_busy();
    test_reset_mid_dump();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_dump_reader.md
# register_dump_reader

Sequential debug reader for the CPU's 32×32-bit register file. On a Start pulse it walks all 32 registers through the file's two combinational read ports, fetching an even/odd pair per read cycle, buffering both words and streaming them out one word per valid/ready handshake with its register index. It sits beside the register file on the debug path, sharing the read ports while the core is halted, and drives a UART or trace sink.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register index width; register count is 2**ADDR_W (even by construction)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- Start  in  1  begin a dump; sampled only in IDLE
- Busy  out  1  high whenever state ≠ IDLE
- Done  out  1  one-cycle pulse after last word accepted
- ReadReg1  out  ADDR_W  to register file read port 1; always {Pair, 1'b0}
- ReadReg2  out  ADDR_W  to register file read port 2; always {Pair, 1'b1}
- ReadData1  in  DATA_W  from register file port 1 (combinational)
- ReadData2  in  DATA_W  from register file port 2 (combinational)
- OutValid  out  1  OutIndex/OutData hold a word
- OutReady  in  1  sink accepts word when OutValid && OutReady at rising edge
- OutIndex  out  ADDR_W  register number of current word
- OutData  out  DATA_W  register contents

## Operation
- Internal: Pair counter (ADDR_W-1 bits), BufLo/BufHi (DATA_W each), FSM {IDLE, FETCH, SEND_LO, SEND_HI, DONE}.
- IDLE: Start=1 → Pair←0, go FETCH. Otherwise stay.
- FETCH: ReadReg1/2 address 2·Pair / 2·Pair+1; at edge BufLo←ReadData1, BufHi←ReadData2; go SEND_LO. No stalls.
- SEND_LO: OutValid=1, OutIndex=2·Pair, OutData=BufLo; OutReady=1 → SEND_HI, else hold.
- SEND_HI: OutValid=1, OutIndex=2·Pair+1, OutData=BufHi; OutReady=1 → if Pair = max then DONE, else Pair←Pair+1, FETCH; else hold.
- DONE: Done=1 for this cycle only; go IDLE unconditionally.
- Start outside IDLE ignored (no restart, no queuing); Start held high through DONE starts a new dump on the cycle after returning to IDLE.
- Register 0 reports whatever the file returns (0 for a conforming file); no special casing here.
- Words emitted strictly in order 0,1,…,31, each exactly once per dump.
- OutIndex/OutData/OutValid stable while OutValid=1 and OutReady=0.
- Buffers capture once per pair; register-file writes after the FETCH edge do not alter the words of that pair.

## Timing
- Reset values: state IDLE, Pair 0, BufLo/BufHi 0, Busy 0, Done 0, OutValid 0, OutIndex 0, OutData 0, ReadReg1 0, ReadReg2 1.
- RST asserted at any time (mid-FETCH, mid-handshake, DONE) forces reset values immediately; a word not yet accepted is dropped, no Done pulse.
- OutValid, Busy, Done derived from registered state only; no combinational path from OutReady to OutValid.
- Start sampled at edge 0 → FETCH in cycle 1, first OutValid in cycle 2.
- OutReady held high: 3 cycles per pair; words accepted at end of cycles 2,3,5,6,…,47,48; Done in cycle 49; IDLE in cycle 50.
- Each cycle of OutReady=0 during SEND_LO/SEND_HI adds exactly one cycle.
- Throughput ceiling 2 words / 3 cycles.

## Test plan
- Reset: assert RST mid-cycle with no clock edge → all outputs at reset values immediately; ReadReg1=0, ReadReg2=1.
- Full dump, OutReady=1, file preloaded reg[i]=0xA5A50000+i (reg0=0): Start at edge 0 → 32 words, indices 0..31, data match, reg0 word 0; Done single pulse cycle 49; Busy high cycles 1..49.
- Backpressure: OutReady toggled 1,0,0,1 pattern → same 32 words in order, OutIndex/OutData unchanged while stalled, no duplicates or drops, Done delayed by exactly the stall count.
- Write during stall: stall in SEND_LO of pair 3, write reg7=0xDEADBEEF → word 7 carries the pre-write value; next dump reports 0xDEADBEEF.
- Start while Busy: pulse Start at cycles 10 and 30 → ignored; exactly one Done, 32 words.
- Reset mid-dump: RST at cycle 20 (pair 6, SEND_LO) → OutValid drops immediately, no Done; new Start yields full 0..31 dump from index 0.
